// File: rtl/state_event_logger_if.sv
// Output stream of the state event logger: FIFO head record with valid/ready handshake.
interface state_event_logger_if #(
    parameter int unsigned EW = 32
);
    logic          valid;
    logic          ready;
    logic [31:0]   ts;
    logic [EW-1:0] evt;

    modport master (output valid, output ts, output evt, input ready);
    modport slave  (input valid, input ts, input evt, output ready);
endinterface

// File: rtl/state_event_logger.sv
// Watches an event vector, timestamps masked changes after arming and queues them
// in a first-word-fall-through FIFO with sticky overflow and saturating drop counter.
module state_event_logger #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned EW    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [EW-1:0]          events_i,
    input  logic [EW-1:0]          event_mask_i,
    input  logic                   arm_i,
    input  logic                   clear_i,
    state_event_logger_if.master   out_if,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   overflow_o,
    output logic [15:0]            drop_count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned RW = 32 + EW;
    localparam logic [LW-1:0] FullLevel = LW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StBaseline, StLog} state_e;

    state_e        state_q, state_d;
    logic [31:0]   ts_q, ts_d;
    logic [EW-1:0] prev_q;
    logic [RW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_q, drop_d;
    logic          change, push, pop, full, wr_en, drop;
    logic [RW-1:0] head;

    assign change = |((events_i ^ prev_q) & event_mask_i);

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arm_i) state_d = StBaseline;
            end
            StBaseline: begin
                push    = 1'b1;
                state_d = arm_i ? StLog : StIdle;
            end
            StLog: begin
                if (!arm_i) state_d = StIdle;
                else if (change) push = 1'b1;
            end
            default: state_d = StIdle;
        endcase
        // Flush wins over any record generated this cycle.
        if (clear_i) begin
            state_d = StIdle;
            push    = 1'b0;
        end
    end

    always_comb begin
        full       = (level_q == FullLevel);
        pop        = (level_q != '0) && out_if.ready;
        wr_en      = push && (!full || pop);
        drop       = push && full && !pop;
        ts_d       = ts_q + 32'd1;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (clear_i) begin
            ts_d       = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
            if (wr_en && !pop)      level_d = level_q + LW'(1);
            else if (!wr_en && pop) level_d = level_q - LW'(1);
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ts_q       <= '0;
            prev_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            prev_q     <= events_i;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {ts_q, events_i};
    end

    assign head         = mem_q[rd_ptr_q];
    assign out_if.valid = (level_q != '0);
    assign out_if.ts    = out_if.valid ? head[RW-1:EW] : '0;
    assign out_if.evt   = out_if.valid ? head[EW-1:0] : '0;
    assign level_o      = level_q;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_q;
endmodule

// File: tb/tb_state_event_logger.sv
// Bench for state_event_logger: vector table, directed multi-cycle sequences and
// randomized traffic checked against a queue-based reference model.
module tb_state_event_logger;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned EW    = 32;
    localparam int MIdle = 0, MBase = 1, MLog = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [EW-1:0] events, mask;
    logic          arm, clr;
    logic [4:0]    level;
    logic          overflow;
    logic [15:0]   drop_count;

    state_event_logger_if #(.EW(EW)) oif ();

    state_event_logger #(.DEPTH(DEPTH), .EW(EW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .events_i     (events),
        .event_mask_i (mask),
        .arm_i        (arm),
        .clear_i      (clr),
        .out_if       (oif),
        .level_o      (level),
        .overflow_o   (overflow),
        .drop_count_o (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic        arm, clr, rdy;
        logic [31:0] ev, mask;
        logic        exp_valid;
        logic [4:0]  exp_level;
        logic [31:0] exp_ts, exp_ev;
    } vec_t;

    vec_t        tbl[10];
    logic [63:0] mq[$];
    logic [31:0] m_ts, m_prev;
    int          m_mode, m_drops;
    logic        m_ovf;
    bit          chk_model;
    int          n_checks, n_fail;
    logic [31:0] got_ts[$], got_ev[$];
    logic [31:0] seqv[5];
    logic [31:0] masks[4];
    int          rdy_pct;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit pop, want;
        if (clr) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
            m_ts    = '0;
            m_mode  = MIdle;
        end else begin
            pop  = (mq.size() != 0) && oif.ready;
            want = 1'b0;
            case (m_mode)
                MIdle: if (arm) m_mode = MBase;
                MBase: begin
                    want   = 1'b1;
                    m_mode = arm ? MLog : MIdle;
                end
                default: begin
                    if (!arm) m_mode = MIdle;
                    else if (((events ^ m_prev) & mask) != 0) want = 1'b1;
                end
            endcase
            if (pop) void'(mq.pop_front());
            if (want) begin
                if (mq.size() < DEPTH) mq.push_back({m_ts, events});
                else begin
                    m_ovf = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end
            end
            m_ts = m_ts + 32'd1;
        end
        m_prev = events;
    endtask

    task automatic compare_model();
        check("model valid", 64'(oif.valid), 64'(mq.size() != 0));
        check("model level", 64'(level), 64'(mq.size()));
        check("model overflow", 64'(overflow), 64'(m_ovf));
        check("model drop_count", 64'(drop_count), 64'(m_drops));
        if (mq.size() > 0) begin
            check("model head ts", 64'(oif.ts), 64'(mq[0][63:32]));
            check("model head event", 64'(oif.evt), 64'(mq[0][31:0]));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        if (chk_model) compare_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        arm = 1'b0; clr = 1'b0; events = '0; mask = '0; oif.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete();
        m_ts = '0; m_prev = '0; m_mode = MIdle; m_ovf = 1'b0; m_drops = 0;
    endtask

    task automatic sample_head();
        if (oif.valid) begin
            got_ts.push_back(oif.ts);
            got_ev.push_back(oif.evt);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; chk_model = 1'b0;
        //            n  arm clr rdy ev          mask         v  lvl ts  ev
        tbl[0] = '{10, 1'b0, 1'b0, 1'b0, 32'h2,     32'hF,       1'b0, 5'd0, 32'd0,  32'h0};
        tbl[1] = '{1,  1'b1, 1'b0, 1'b0, 32'h2,     32'hF,       1'b0, 5'd0, 32'd0,  32'h0};
        tbl[2] = '{1,  1'b1, 1'b0, 1'b0, 32'h2,     32'hF,       1'b1, 5'd1, 32'd11, 32'h2};
        tbl[3] = '{5,  1'b1, 1'b0, 1'b0, 32'h2,     32'hF,       1'b1, 5'd1, 32'd11, 32'h2};
        tbl[4] = '{1,  1'b1, 1'b0, 1'b0, 32'h102,   32'h3000F,   1'b1, 5'd1, 32'd11, 32'h2};
        tbl[5] = '{1,  1'b1, 1'b0, 1'b0, 32'h20102, 32'h3000F,   1'b1, 5'd2, 32'd11, 32'h2};
        tbl[6] = '{1,  1'b1, 1'b0, 1'b1, 32'h20102, 32'h3000F,   1'b1, 5'd1, 32'd18, 32'h20102};
        tbl[7] = '{1,  1'b1, 1'b0, 1'b1, 32'h20102, 32'h3000F,   1'b0, 5'd0, 32'd0,  32'h0};
        tbl[8] = '{1,  1'b0, 1'b0, 1'b1, 32'h20106, 32'h3000F,   1'b0, 5'd0, 32'd0,  32'h0};
        tbl[9] = '{2,  1'b0, 1'b0, 1'b1, 32'h7,     32'h3000F,   1'b0, 5'd0, 32'd0,  32'h0};
        seqv  = '{32'h2, 32'h4, 32'h5, 32'h6, 32'h7};
        masks = '{32'hF, 32'h0003_000F, 32'hFFFF_FFFF, 32'h0};

        do_reset();
        check("reset valid", 64'(oif.valid), 64'd0);
        check("reset level", 64'(level), 64'd0);
        check("reset overflow", 64'(overflow), 64'd0);
        check("reset drop_count", 64'(drop_count), 64'd0);
        check("reset out_ts", 64'(oif.ts), 64'd0);
        check("reset out_event", 64'(oif.evt), 64'd0);

        for (int r = 0; r < 10; r++) begin
            arm = tbl[r].arm; clr = tbl[r].clr; oif.ready = tbl[r].rdy;
            events = tbl[r].ev; mask = tbl[r].mask;
            for (int k = 0; k < tbl[r].n; k++) begin
                step();
                check($sformatf("vec%0d valid", r), 64'(oif.valid), 64'(tbl[r].exp_valid));
                check($sformatf("vec%0d level", r), 64'(level), 64'(tbl[r].exp_level));
                check($sformatf("vec%0d ts", r), 64'(oif.ts), 64'(tbl[r].exp_ts));
                check($sformatf("vec%0d event", r), 64'(oif.evt), 64'(tbl[r].exp_ev));
            end
        end
        check("vec overflow", 64'(overflow), 64'd0);

        // Five changes three cycles apart, consumer always ready.
        chk_model = 1'b1;
        do_reset();
        mask = 32'hF; oif.ready = 1'b1; arm = 1'b1; events = 32'h2;
        step();
        got_ts.delete(); got_ev.delete();
        for (int i = 0; i < 5; i++) begin
            events = seqv[i];
            repeat (3) begin
                step();
                sample_head();
            end
        end
        repeat (3) begin
            step();
            sample_head();
        end
        check("spacing count", 64'(got_ts.size()), 64'd5);
        for (int k = 0; k < 5 && k < got_ts.size(); k++) begin
            check($sformatf("spacing ts%0d", k), 64'(got_ts[k]), 64'(1 + 3 * k));
            check($sformatf("spacing ev%0d", k), 64'(got_ev[k]), 64'(seqv[k]));
        end

        // Overflow with consumer stalled, then push+pop while full, then drain.
        do_reset();
        mask = 32'hF; arm = 1'b1; events = '0;
        step();
        for (int i = 0; i < 20; i++) begin
            events = 32'(i % 16);
            step();
        end
        check("full level", 64'(level), 64'd16);
        check("full overflow", 64'(overflow), 64'd1);
        check("full drop_count", 64'(drop_count), 64'd4);
        events = 32'hA; oif.ready = 1'b1;
        step();
        check("full pushpop level", 64'(level), 64'd16);
        check("full pushpop drops", 64'(drop_count), 64'd4);
        check("full pushpop head", 64'(oif.ts), 64'd2);
        arm = 1'b0;
        got_ts.delete(); got_ev.delete();
        for (int c = 0; c < 40; c++) begin
            if (!oif.valid) break;
            sample_head();
            step();
        end
        check("drain count", 64'(got_ts.size()), 64'd16);
        check("drain valid", 64'(oif.valid), 64'd0);
        for (int k = 0; k < 16 && k < got_ts.size(); k++) begin
            check($sformatf("drain ts%0d", k), 64'(got_ts[k]), (k < 15) ? 64'(k + 2) : 64'd21);
            check($sformatf("drain ev%0d", k), 64'(got_ev[k]), (k < 15) ? 64'(k + 1) : 64'hA);
        end

        // Clear coincident with a change at level 5.
        do_reset();
        mask = 32'hF; arm = 1'b1; events = '0;
        step();
        step();
        for (int i = 1; i < 5; i++) begin
            events = 32'(i);
            step();
        end
        check("preclear level", 64'(level), 64'd5);
        clr = 1'b1; events = 32'h5;
        step();
        clr = 1'b0;
        check("clear level", 64'(level), 64'd0);
        check("clear valid", 64'(oif.valid), 64'd0);
        check("clear overflow", 64'(overflow), 64'd0);
        step();
        check("post-clear idle", 64'(level), 64'd0);
        step();
        check("post-clear baseline level", 64'(level), 64'd1);
        check("post-clear baseline ts", 64'(oif.ts), 64'd1);
        check("post-clear baseline ev", 64'(oif.evt), 64'h5);
        rst_n = 1'b0;
        #1;
        check("async reset level", 64'(level), 64'd0);
        check("async reset valid", 64'(oif.valid), 64'd0);
        check("async reset out_ts", 64'(oif.ts), 64'd0);

        // Randomized traffic against the reference model.
        do_reset();
        rdy_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                rdy_pct = (c % 750 == 0) ? 5 : ((c % 500 == 0) ? 95 : 50);
                mask = masks[$urandom_range(0, 3)];
            end
            arm = ($urandom_range(0, 29) != 0);
            clr = ($urandom_range(0, 299) == 0);
            oif.ready = (int'($urandom_range(0, 99)) < rdy_pct);
            if ($urandom_range(0, 9) < 4) events = events ^ (32'd1 << $urandom_range(0, 31));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/state_event_logger.md
STATE_EVENT_LOGGER -- requirements
Module: state_event_logger

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, 4..256.
REQ-002 Parameter EW, default 32, width of captured event vector.
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 events_in  input  EW  monitored vector from DUT; bits[3:0]=fsm_state, [16]=busy, [17]=done, [27:20]=data_out.
REQ-006 event_mask  input  EW  1 = bit participates in change detection; data is recorded unmasked.
REQ-007 arm  input  1  level; 1 = logging enabled.
REQ-008 clear  input  1  synchronous flush pulse.
REQ-009 out_valid  output  1  FIFO head valid.
REQ-010 out_ready  input  1  consumer accepts head.
REQ-011 out_ts  output  32  timestamp of head record.
REQ-012 out_event  output  EW  event vector of head record.
REQ-013 level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 overflow  output  1  sticky; a record was dropped.
REQ-015 drop_count  output  16  number of dropped records, saturating.

Function
REQ-016 Timestamp counter ts: 32 bits, +1 every cycle, wraps 0xFFFFFFFF->0; cleared to 0 by clear.
REQ-017 prev register holds events_in of previous cycle; updated every cycle regardless of arm.
REQ-018 Change condition: ((events_in ^ prev) & event_mask) != 0.
REQ-019 FSM states IDLE, BASELINE, LOG.
REQ-020 IDLE: arm=1 -> BASELINE; no records pushed.
REQ-021 BASELINE: one cycle; unconditionally push {ts, events_in}; -> LOG if arm=1, else IDLE.
REQ-022 LOG: on change condition push {ts, events_in}; arm=0 -> IDLE (no push in that cycle).
REQ-023 Push latency: record pushed at edge N visible on out_* with out_valid=1 at cycle N+1; out_ts equals ts sampled at edge N.
REQ-024 FIFO is first-word-fall-through; out_valid = (level != 0); out_ts/out_event show oldest entry.
REQ-025 Pop occurs when out_valid && out_ready; out_* stable while out_valid && !out_ready.
REQ-026 Push when full and no pop: record dropped, overflow <= 1, drop_count += 1 saturating at 0xFFFF.
REQ-027 Push and pop same cycle when full: push accepted, level unchanged, no drop.
REQ-028 Push and pop same cycle when non-full, non-empty: level unchanged.
REQ-029 Pop when empty: ignored.
REQ-030 Pointers wrap modulo DEPTH; level never exceeds DEPTH.
REQ-031 clear: level<=0, overflow<=0, drop_count<=0, ts<=0, FSM -> IDLE; takes precedence over push/pop in same cycle.
REQ-032 event_mask=0 in LOG: only the BASELINE record is produced.

Reset
REQ-033 rst_n low: FSM=IDLE, level=0, out_valid=0, overflow=0, drop_count=0, ts=0, prev=0, FIFO pointers 0.
REQ-034 out_ts and out_event read 0 while empty after reset.
REQ-035 Reset asserted mid-operation discards all stored records immediately; no push on first edge after release unless FSM reaches BASELINE.

Verification
REQ-036 Reset, arm=1 at cycle 10, events_in=0x2, mask=0xF -> one record {ts=11, event=0x2} valid at cycle 12; no further records while stable.
REQ-037 events_in sequence 0x2->0x4->0x5->0x6->0x7 one change per 3 cycles, out_ready=1 -> 5 records (incl. baseline) in order, ts spacing 3.
REQ-038 DEPTH=16, out_ready=0, 20 changes -> level=16, overflow=1, drop_count=4; then out_ready=1 drains 16 in order, out_valid=0.
REQ-039 Full FIFO, out_ready=1 and change same cycle -> level stays 16, drop_count unchanged.
REQ-040 Change only on bit 8 with mask=0x0003_000F -> no record; change on bit 17 -> record.
REQ-041 clear asserted same cycle as a change with level=5 -> level=0, overflow=0, ts=0 next cycle, FSM IDLE, no record.
